cla_16bit: RTL and testbench

Registered 16-bit signed add/subtract unit built from carry-lookahead logic, with two's-complement saturation and an overflow flag. It serves as the ALU's ADD/SUB datapath, and also as the adder for any path that needs a saturating 16-bit sum. Operands are combined combinationally through a two-level carry-lookahead tree. Results are captured in an output register on the rising clock edge.

---
 rtl/alu_pkg.sv | 6 +
 rtl/cla_4bit.sv | 26 ++
 rtl/cla_16bit.sv | 81 ++++++++
 tb/tb_cla_16bit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU add/subtract datapath.
package alu_pkg;
    localparam int unsigned DATA_W = 16;
    localparam logic [DATA_W-1:0] SAT_POS = 16'h7FFF;
    localparam logic [DATA_W-1:0] SAT_NEG = 16'h8000;
endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead group: sum bits plus group generate/propagate for the
// second-level lookahead unit.
module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] s_o,
    output logic       g_o,
    output logic       p_o
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g = a_i & b_i;
        p = a_i ^ b_i;
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin_i);
        s_o  = p ^ c;
        g_o  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
        p_o  = &p;
    end
endmodule

// File: rtl/cla_16bit.sv
// Registered 16-bit signed add/subtract with two-level carry lookahead,
// two's-complement saturation and an overflow flag.
module cla_16bit
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              v
);
    logic [DATA_W-1:0] beff;
    logic [DATA_W-1:0] raw;
    logic [3:0]        grp_g;
    logic [3:0]        grp_p;
    logic [4:0]        grp_c;
    logic              pos_ovf;
    logic              neg_ovf;

    logic [DATA_W-1:0] sum_d, sum_q;
    logic              cout_d, cout_q;
    logic              v_d, v_q;

    assign beff = sub ? ~b : b;

    for (genvar i = 0; i < 4; i++) begin : g_grp
        cla_4bit u_cla_4bit (
            .a_i   (a[4*i +: 4]),
            .b_i   (beff[4*i +: 4]),
            .cin_i (grp_c[i]),
            .s_o   (raw[4*i +: 4]),
            .g_o   (grp_g[i]),
            .p_o   (grp_p[i])
        );
    end

    // Each group carry is expanded from cin directly so no carry ripples between groups.
    always_comb begin
        grp_c[0] = sub;
        grp_c[1] = grp_g[0] | (grp_p[0] & sub);
        grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & sub);
        grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[2] & grp_p[1] & grp_p[0] & sub);
        grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                 | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & sub);
    end

    always_comb begin
        pos_ovf = ~a[DATA_W-1] & ~beff[DATA_W-1] & raw[DATA_W-1];
        neg_ovf = a[DATA_W-1] & beff[DATA_W-1] & ~raw[DATA_W-1];
        if (pos_ovf) begin
            sum_d = SAT_POS;
        end else if (neg_ovf) begin
            sum_d = SAT_NEG;
        end else begin
            sum_d = raw;
        end
        cout_d = grp_c[4];
        v_d    = pos_ovf | neg_ovf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            v_q    <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            v_q    <= v_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;
    assign v    = v_q;
endmodule

// File: tb/tb_cla_16bit.sv
// Self-checking bench for cla_16bit: directed vectors with literal results plus an
// integer-arithmetic saturating model checked on every cycle.
module tb_cla_16bit;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] a, b;
    logic        sub;
    logic [15:0] sum;
    logic        cout, v;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_sum;
    logic        exp_cout, exp_v;
    logic        exp_valid = 1'b0;

    cla_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .a    (a),
        .b    (b),
        .sub  (sub),
        .sum  (sum),
        .cout (cout),
        .v    (v)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [15:0] ma, input logic [15:0] mb, input logic ms,
                                  output logic [15:0] es, output logic ec, output logic ev);
        int sa, sb, r, ua, ub;
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        ua = int'({16'h0, ma});
        ub = int'({16'h0, mb});
        r  = ms ? sa - sb : sa + sb;
        if (r > 32767) begin
            es = 16'h7FFF;
            ev = 1'b1;
        end else if (r < -32768) begin
            es = 16'h8000;
            ev = 1'b1;
        end else begin
            es = r[15:0];
            ev = 1'b0;
        end
        // a - b = a + ~b + 1 carries out exactly when a >= b unsigned
        ec = ms ? (ua >= ub) : (ua + ub > 65535);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            exp_sum  <= 16'h0000;
            exp_cout <= 1'b0;
            exp_v    <= 1'b0;
        end else begin
            logic [15:0] s_t;
            logic        c_t, v_t;
            model(a, b, sub, s_t, c_t, v_t);
            exp_sum  <= s_t;
            exp_cout <= c_t;
            exp_v    <= v_t;
        end
        exp_valid <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (sum !== exp_sum || cout !== exp_cout || v !== exp_v) begin
                errors++;
                $display("FAIL model: sum=%h cout=%b v=%b, expected sum=%h cout=%b v=%b",
                         sum, cout, v, exp_sum, exp_cout, exp_v);
            end
        end
    end

    task automatic vec(input string name, input logic [15:0] va, input logic [15:0] vb,
                       input logic vs, input logic [15:0] es, input logic ec, input logic ev);
        @(negedge clk);
        a   = va;
        b   = vb;
        sub = vs;
        @(posedge clk);
        #1;
        checks++;
        if (sum !== es || cout !== ec || v !== ev) begin
            errors++;
            $display("FAIL %s: sum=%h cout=%b v=%b, expected sum=%h cout=%b v=%b",
                     name, sum, cout, v, es, ec, ev);
        end
    endtask

    initial begin
        rst = 1'b1;
        a   = 16'h1234;
        b   = 16'h1111;
        sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL reset: sum=%h cout=%b v=%b, expected 0000 0 0", sum, cout, v);
        end
        @(negedge clk);
        rst = 1'b0;

        vec("add_in_range",  16'd20000, 16'd10000, 1'b0, 16'd30000, 1'b0, 1'b0);
        vec("sub_in_range",  16'd20000, 16'd10000, 1'b1, 16'd10000, 1'b1, 1'b0);
        vec("pos_sat",       16'h7FFF,  16'd100,   1'b0, 16'h7FFF,  1'b0, 1'b1);
        vec("neg_sat_add",   16'h8001,  16'hFB2E,  1'b0, 16'h8000,  1'b1, 1'b1);
        vec("neg_sat_sub",   16'h8000,  16'h0001,  1'b1, 16'h8000,  1'b1, 1'b1);
        vec("sub_min",       16'h0000,  16'h8000,  1'b1, 16'h7FFF,  1'b0, 1'b1);
        vec("unsigned_wrap", 16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0);
        vec("sub_zero",      16'h0005,  16'h0000,  1'b1, 16'h0005,  1'b1, 1'b0);
        vec("sub_to_neg",    16'h0003,  16'h0005,  1'b1, 16'hFFFE,  1'b0, 1'b0);
        vec("min_minus_min", 16'h8000,  16'h8000,  1'b1, 16'h0000,  1'b1, 1'b0);

        // Reset mid-stream discards the inputs present at that edge.
        @(negedge clk);
        rst = 1'b1;
        a   = 16'h7FFF;
        b   = 16'h7FFF;
        @(posedge clk);
        #1;
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0 || v !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: sum=%h cout=%b v=%b, expected 0000 0 0", sum, cout, v);
        end
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a   = 16'($urandom);
            b   = 16'($urandom);
            sub = 1'($urandom);
            if (i % 7 == 0) b = 16'h8000;
            if (i % 11 == 0) a = 16'h7FFF;
        end
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
